// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Lock support is selected by the RAM_ARB_LOCK_EN macro in ram_arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        OWN0     = 2'b01,
        OWN1     = 2'b10
    } lock_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    // Round-robin pointer after a grant: favour whoever did not just win.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational two-way round-robin pick: a lone eligible request wins,
// a tie is broken by the pointer.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
(
    input  logic elig0_i,
    input  logic elig1_i,
    input  logic ptr_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    // Winner selection
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = REQ_CPU;
        case ({elig1_i, elig0_i})
            2'b01: begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = REQ_CPU;
            end
            2'b10: begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = REQ_DMA;
            end
            2'b11: begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = ptr_i;
            end
            default: begin
                gnt_valid_o = 1'b0;
                gnt_id_o    = REQ_CPU;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between CPU (0) and DMA (1).
// Define RAM_ARB_LOCK_EN to build the ownership lock for read-modify-write.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_Rst_n,
    input  logic          i_Req0,
    input  logic          i_Req1,
    input  logic          i_WR0,
    input  logic          i_WR1,
    input  logic [AW-1:0] i_Address0,
    input  logic [AW-1:0] i_Address1,
    input  logic [DW-1:0] i_DataIn0,
    input  logic [DW-1:0] i_DataIn1,
    input  logic          i_Lock0,
    input  logic          i_Lock1,
    output logic          o_Ack0,
    output logic          o_Ack1,
    output logic          o_RdValid0,
    output logic          o_RdValid1,
    output logic [DW-1:0] o_RdData,
    output logic [AW-1:0] o_RamAddress,
    output logic [DW-1:0] o_RamDataIn,
    output logic          o_RamWR,
    input  logic [DW-1:0] i_RamDataOut
);

    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          rdvalid0_q, rdvalid0_d;
    logic          rdvalid1_q, rdvalid1_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_wr_q, ram_wr_d;
    logic          ptr_q, ptr_d;
    rd_tag_t       tag_q, tag_d;
    lock_state_e   lock_s;

    logic          elig0_s, elig1_s;
    logic          gnt_valid_s, gnt_id_s;
    logic          win_wr_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_din_s;

    // A requester whose Ack is still high is presenting the request just accepted.
    assign elig0_s = i_Req0 & ~ack0_q & (lock_s != OWN1);
    assign elig1_s = i_Req1 & ~ack1_q & (lock_s != OWN0);

    ram_arb_rr_pick u_pick (
        .elig0_i     (elig0_s),
        .elig1_i     (elig1_s),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    assign win_wr_s   = (gnt_id_s == REQ_DMA) ? i_WR1      : i_WR0;
    assign win_addr_s = (gnt_id_s == REQ_DMA) ? i_Address1 : i_Address0;
    assign win_din_s  = (gnt_id_s == REQ_DMA) ? i_DataIn1  : i_DataIn0;

`ifdef RAM_ARB_LOCK_EN
    lock_state_e lock_q, lock_d;
    logic        win_lock_s;

    assign win_lock_s = (gnt_id_s == REQ_DMA) ? i_Lock1 : i_Lock0;
    assign lock_s     = lock_q;

    // Lock ownership next state; only the owner's unlocked access releases it
    always_comb begin
        lock_d = lock_q;
        if (gnt_valid_s) begin
            case (lock_q)
                UNLOCKED: begin
                    if (win_lock_s) begin
                        lock_d = (gnt_id_s == REQ_DMA) ? OWN1 : OWN0;
                    end else begin
                        lock_d = UNLOCKED;
                    end
                end
                OWN0: begin
                    if ((gnt_id_s == REQ_CPU) && !win_lock_s) begin
                        lock_d = UNLOCKED;
                    end else begin
                        lock_d = OWN0;
                    end
                end
                OWN1: begin
                    if ((gnt_id_s == REQ_DMA) && !win_lock_s) begin
                        lock_d = UNLOCKED;
                    end else begin
                        lock_d = OWN1;
                    end
                end
                default: lock_d = UNLOCKED;
            endcase
        end else begin
            lock_d = lock_q;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lock_q <= UNLOCKED;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock_s;

    assign unused_lock_s = i_Lock0 ^ i_Lock1;
    assign lock_s        = UNLOCKED;
`endif

    // Grant bookkeeping and RAM command next state; no grant leaves a harmless read
    always_comb begin
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ram_wr_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        tag_d      = '0;
        ptr_d      = ptr_q;
        if (gnt_valid_s) begin
            ack0_d      = (gnt_id_s == REQ_CPU);
            ack1_d      = (gnt_id_s == REQ_DMA);
            ram_wr_d    = win_wr_s;
            ram_addr_d  = win_addr_s;
            ram_din_d   = win_din_s;
            tag_d.valid = ~win_wr_s;
            tag_d.id    = gnt_id_s;
            ptr_d       = other_req(gnt_id_s);
        end else begin
            ack0_d   = 1'b0;
            ack1_d   = 1'b0;
            ram_wr_d = 1'b0;
        end
        rdvalid0_d = tag_q.valid && (tag_q.id == REQ_CPU);
        rdvalid1_d = tag_q.valid && (tag_q.id == REQ_DMA);
    end

    // Arbiter output and tag registers
    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdvalid0_q <= 1'b0;
            rdvalid1_q <= 1'b0;
            ram_addr_q <= {AW{1'b0}};
            ram_din_q  <= {DW{1'b0}};
            ram_wr_q   <= 1'b0;
            ptr_q      <= REQ_CPU;
            tag_q      <= '0;
        end else begin
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdvalid0_q <= rdvalid0_d;
            rdvalid1_q <= rdvalid1_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_wr_q   <= ram_wr_d;
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
        end
    end

    assign o_Ack0       = ack0_q;
    assign o_Ack1       = ack1_q;
    assign o_RdValid0   = rdvalid0_q;
    assign o_RdValid1   = rdvalid1_q;
    assign o_RamAddress = ram_addr_q;
    assign o_RamDataIn  = ram_din_q;
    assign o_RamWR      = ram_wr_q;
    assign o_RdData     = i_RamDataOut;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural synchronous 256x8 RAM.
// Expectations adapt to whether RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic       lk0 = 1'b0, lk1 = 1'b0;
    logic [7:0] a0 = 8'h00, a1 = 8'h00, d0 = 8'h00, d1 = 8'h00;
    logic       ack0, ack1, rv0, rv1, ram_wr;
    logic [7:0] rd_data, ram_addr, ram_din;
    logic [7:0] ram_dout = 8'h00;
    logic [7:0] mem [256];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(8), .DW(8)) dut (
        .clk          (clk),
        .i_Rst_n      (rst_n),
        .i_Req0       (req0),
        .i_Req1       (req1),
        .i_WR0        (wr0),
        .i_WR1        (wr1),
        .i_Address0   (a0),
        .i_Address1   (a1),
        .i_DataIn0    (d0),
        .i_DataIn1    (d1),
        .i_Lock0      (lk0),
        .i_Lock1      (lk1),
        .o_Ack0       (ack0),
        .o_Ack1       (ack1),
        .o_RdValid0   (rv0),
        .o_RdValid1   (rv1),
        .o_RdData     (rd_data),
        .o_RamAddress (ram_addr),
        .o_RamDataIn  (ram_din),
        .o_RamWR      (ram_wr),
        .i_RamDataOut (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ack0, ack1, rv0, rv1, ram_wr} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, rv0, rv1, ram_wr});
        end
        n_cmp++;
        if ({ram_addr, ram_din} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_bus: got %h expected 0000", {ram_addr, ram_din});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic write0(input logic [7:0] addr, input logic [7:0] data);
        req0 = 1'b1; wr0 = 1'b1; a0 = addr; d0 = data;
        step();
        n_cmp++;
        if ({ack0, ram_wr, ram_addr, ram_din} !== {1'b1, 1'b1, addr, data}) begin
            n_bad++; $display("FAIL write_cmd: got %b/%b/%h/%h expected 1/1/%h/%h", ack0, ram_wr, ram_addr, ram_din, addr, data);
        end
        req0 = 1'b0; wr0 = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        write0(8'h10, 8'hA5);
        n_cmp++;
        if ({ack0, ram_wr} !== 2'b00) begin
            n_bad++; $display("FAIL write_idle: got %b expected 00", {ack0, ram_wr});
        end
        req0 = 1'b1; a0 = 8'h10;
        step();
        n_cmp++;
        if (ack0 !== 1'b1) begin n_bad++; $display("FAIL read_ack0: got %b expected 1", ack0); end
        q0.push_back(8'hA5);
        req0 = 1'b0;
        step();
        n_cmp++;
        if ({rv0, rv1} !== 2'b10) begin n_bad++; $display("FAIL read_rv: got %b expected 10", {rv0, rv1}); end
        if (rv0 && q0.size() > 0) begin
            logic [7:0] e;
            e = q0.pop_front();
            n_cmp++;
            if (rd_data !== e) begin n_bad++; $display("FAIL read_data0: got %h expected %h", rd_data, e); end
        end
        step();
        n_cmp++;
        if ({rv0, rv1} !== 2'b00) begin n_bad++; $display("FAIL read_rv_end: got %b expected 00", {rv0, rv1}); end
        // preload for later scenarios
        write0(8'h01, 8'h11);
        write0(8'h02, 8'h22);
        write0(8'h03, 8'h33);
        write0(8'h05, 8'h55);
        write0(8'h20, 8'h44);
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; a0 = 8'h01;
        req1 = 1'b1; wr1 = 1'b0; a1 = 8'h02;
        for (int i = 1; i <= 9; i++) begin
            logic g0, erv0, erv1;
            if (i == 9) begin req0 = 1'b0; req1 = 1'b0; end
            step();
            g0   = (i % 2) == 1;
            erv0 = (i > 1) && ((i % 2) == 0);
            erv1 = (i > 1) && ((i % 2) == 1);
            if (i <= 8) begin
                n_cmp++;
                if ({ack0, ack1} !== {g0, ~g0}) begin
                    n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {ack0, ack1}, {g0, ~g0});
                end
            end
            n_cmp++;
            if ({rv0, rv1} !== {erv0, erv1}) begin
                n_bad++; $display("FAIL rr_rdvalid[%0d]: got %b expected %b", i, {rv0, rv1}, {erv0, erv1});
            end
            if (rv0 && q0.size() > 0) begin
                logic [7:0] e;
                e = q0.pop_front();
                n_cmp++;
                if (rd_data !== e) begin n_bad++; $display("FAIL rr_data0[%0d]: got %h expected %h", i, rd_data, e); end
            end
            if (rv1 && q1.size() > 0) begin
                logic [7:0] e;
                e = q1.pop_front();
                n_cmp++;
                if (rd_data !== e) begin n_bad++; $display("FAIL rr_data1[%0d]: got %h expected %h", i, rd_data, e); end
            end
            if (i <= 8) begin
                if (g0) q0.push_back(8'h11);
                else    q1.push_back(8'h22);
            end
        end
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++; $display("FAIL rr_drain: got %0d expected 0", q0.size() + q1.size());
        end
    endtask

    task automatic test_held_req();
        int  acks = 0;
        logic prev = 1'b0;
        step();
        req0 = 1'b1; wr0 = 1'b0; a0 = 8'h05;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) req0 = 1'b0;
            step();
            if (rv0 && q0.size() > 0) begin
                logic [7:0] e;
                e = q0.pop_front();
                n_cmp++;
                if (rd_data !== e) begin n_bad++; $display("FAIL held_data[%0d]: got %h expected %h", i, rd_data, e); end
            end
            if (ack0 && i <= 6) begin
                acks++;
                n_cmp++;
                if (prev) begin n_bad++; $display("FAIL held_consecutive[%0d]: got 1 expected 0", i); end
                q0.push_back(8'h55);
            end
            prev = ack0;
        end
        n_cmp++;
        if (acks != 3) begin n_bad++; $display("FAIL held_acks: got %0d expected 3", acks); end
        n_cmp++;
        if (q0.size() != 0) begin n_bad++; $display("FAIL held_drain: got %0d expected 0", q0.size()); end
    endtask

    task automatic test_lock();
        step();
        req1 = 1'b1; wr1 = 1'b0; a1 = 8'h20; lk1 = 1'b1;
        step();
        n_cmp++;
        if ({ack0, ack1} !== 2'b01) begin n_bad++; $display("FAIL lock_take: got %b expected 01", {ack0, ack1}); end
        q1.push_back(8'h44);
        req1 = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; a0 = 8'h03;
        for (int i = 1; i <= 7; i++) begin
            logic e0, e1;
            if (i == 5) begin req1 = 1'b1; wr1 = 1'b1; d1 = 8'h5A; lk1 = 1'b0; end
            if (i == 6) req1 = 1'b0;
            if (i == 7) req0 = 1'b0;
`ifdef RAM_ARB_LOCK_EN
            e0 = (i == 6);
`else
            e0 = (i == 1) || (i == 3) || (i == 6);
`endif
            e1 = (i == 5);
            step();
            n_cmp++;
            if ({ack0, ack1} !== {e0, e1}) begin
                n_bad++; $display("FAIL lock_grant[%0d]: got %b expected %b", i, {ack0, ack1}, {e0, e1});
            end
            if (rv0 && q0.size() > 0) begin
                logic [7:0] e;
                e = q0.pop_front();
                n_cmp++;
                if (rd_data !== e) begin n_bad++; $display("FAIL lock_data0[%0d]: got %h expected %h", i, rd_data, e); end
            end
            if (rv1 && q1.size() > 0) begin
                logic [7:0] e;
                e = q1.pop_front();
                n_cmp++;
                if (rd_data !== e) begin n_bad++; $display("FAIL lock_data1[%0d]: got %h expected %h", i, rd_data, e); end
            end
            if (e0) q0.push_back(8'h33);
        end
        req0 = 1'b1; a0 = 8'h20;
        step();
        n_cmp++;
        if (ack0 !== 1'b1) begin n_bad++; $display("FAIL lock_readback_ack: got %b expected 1", ack0); end
        q0.push_back(8'h5A);
        req0 = 1'b0;
        step();
        if (rv0 && q0.size() > 0) begin
            logic [7:0] e;
            e = q0.pop_front();
            n_cmp++;
            if (rd_data !== e) begin n_bad++; $display("FAIL lock_readback: got %h expected %h", rd_data, e); end
        end
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++; $display("FAIL lock_drain: got %0d expected 0", q0.size() + q1.size());
        end
    endtask

    task automatic test_async_reset();
        step();
        req0 = 1'b1; wr0 = 1'b0; a0 = 8'h01;
        step();
        n_cmp++;
        if (ack0 !== 1'b1) begin n_bad++; $display("FAIL arst_pre_ack: got %b expected 1", ack0); end
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack0, ack1, rv0, rv1, ram_wr, ram_addr, ram_din} !== 21'h0) begin
            n_bad++; $display("FAIL arst_outputs: got %h expected 0", {ack0, ack1, rv0, rv1, ram_wr, ram_addr, ram_din});
        end
        step();
        n_cmp++;
        if ({rv0, rv1} !== 2'b00) begin n_bad++; $display("FAIL arst_rdvalid: got %b expected 00", {rv0, rv1}); end
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 8'h01;
        req1 = 1'b1; wr1 = 1'b0; a1 = 8'h02;
        step();
        n_cmp++;
        if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL arst_first_grant: got %b expected 10", {ack0, ack1}); end
        q0.push_back(8'h11);
        req0 = 1'b0; req1 = 1'b0;
        step();
        n_cmp++;
        if ({rv0, rv1} !== 2'b10) begin n_bad++; $display("FAIL arst_rv: got %b expected 10", {rv0, rv1}); end
        if (rv0 && q0.size() > 0) begin
            logic [7:0] e;
            e = q0.pop_front();
            n_cmp++;
            if (rd_data !== e) begin n_bad++; $display("FAIL arst_data: got %h expected %h", rd_data, e); end
        end
        step();
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++; $display("FAIL arst_drain: got %0d expected 0", q0.size() + q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_held_req();
        test_lock();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares the single-port 256×8 data RAM between two requesters: requester 0 is the CPU core and requester 1 is the DMA/peripheral side.
- Grants one RAM access per cycle using round-robin, and drives the RAM's address, data-in and write-enable from registers.
- Routes the RAM's registered read data back to the requester that issued the read.
- Optionally lets one requester hold the RAM across several accesses for atomic read-modify-write.

## Interface
Parameters:
- AW, 8, address width; RAM depth is 2^AW.
- DW, 8, data width.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Req0 / i_Req1  in  1  access request from requester 0 / 1.
- i_WR0 / i_WR1  in  1  1 = write, 0 = read.
- i_Address0 / i_Address1  in  AW  access address.
- i_DataIn0 / i_DataIn1  in  DW  write data.
- i_Lock0 / i_Lock1  in  1  keep ownership after this access.
- o_Ack0 / o_Ack1  out  1  one-cycle pulse: the request has been accepted.
- o_RdValid0 / o_RdValid1  out  1  one-cycle pulse: o_RdData holds this requester's read result.
- o_RdData  out  DW  read data, passed straight through from i_RamDataOut.
- o_RamAddress  out  AW  registered address to the RAM.
- o_RamDataIn  out  DW  registered write data to the RAM.
- o_RamWR  out  1  registered write enable to the RAM.
- i_RamDataOut  in  DW  registered read data from the RAM.

## Operation
Request rules:
- A requester holds Req, WR, Address, DataIn and Lock stable until it sees its Ack.
- A request sampled while that requester's own Ack is high is ignored. This keeps a held Req from being issued twice.
- As a result, each requester can be accepted at most every other cycle.
- At each edge, the eligible requests are those with Req=1, own Ack low, and passing the lock filter.

Selecting the winner:
- If only one request is eligible, it wins.
- If both are eligible, the round-robin pointer picks the winner. After each grant the pointer moves to favour the other requester.

Registered on a grant:
- o_RamAddress, o_RamDataIn and o_RamWR take the winner's values.
- The winner's Ack goes high.
- A read tag {valid = !WR, id} is recorded.

Registered with no grant:
- o_RamWR = 0 and o_Ack* = 0.
- o_RamAddress keeps its value, so the RAM performs a harmless read.

Read return:
- At the next edge, the read tag becomes o_RdValid<id>.
- Writes never produce RdValid.

Lock state machine (states UNLOCKED, OWN0, OWN1):
- UNLOCKED → OWNn when requester n is granted with Lock=1.
- OWNn → UNLOCKED when requester n is granted with Lock=0.
- In OWNn, the other requester is never eligible.

## Timing
Latency:
- Edge E0 samples the request and grants it; Ack is high in cycle E0..E1.
- At E1 the RAM performs the access; o_RdValid is high in cycle E1..E2 with the data valid on o_RdData.
- Read latency from the sampling edge to data valid is 2 edges; accepting a write takes 1 edge.

Throughput:
- With both requesters active, one access is issued every cycle, alternating 0,1,0,1.

Reset values (asserted asynchronously):
- o_Ack*, o_RdValid*, o_RamWR, o_RamAddress and o_RamDataIn are 0.
- The pointer favours requester 0.
- The lock state is UNLOCKED and the read tag is cleared.
- A read in flight when reset asserts never produces RdValid.

Boundary conditions:
- Address 0xFF needs no special handling; there is no wrap logic.
- If a requester deasserts Req while waiting, nothing is issued for it.
- If the lock owner stops requesting, the lock persists and the other requester waits (no timeout).

## Configuration
- RAM_ARB_LOCK_EN defined: the lock state machine and lock filter are built as described above.
- RAM_ARB_LOCK_EN undefined: the i_Lock* ports remain but are ignored, the lock state is fixed at UNLOCKED, and arbitration is pure round-robin.

## Structure
- Package ram_arb_pkg holds:
  - the lock-state enum {UNLOCKED, OWN0, OWN1};
  - the requester-id constants REQ_CPU = 0 and REQ_DMA = 1;
  - the read-tag struct {valid, id}.
- One sub-module, ram_arb_rr_pick, is combinational. It takes the two eligible bits plus the pointer and returns grant-valid and grant-id.

## Test plan
- Write then read back, requester 0 alone: write 0xA5 to 0x10, then read 0x10. Expect o_Ack0 one edge after each request and o_RdValid0 with o_RdData=0xA5 two edges after the read is sampled; o_RdValid1 stays 0.
- Both requesters hold reads continuously (req0 at 0x01, req1 at 0x02, memory preloaded 0x11/0x22). Expect grants alternating 0,1,0,1 starting with 0 after reset, and RdValid0 with 0x11 / RdValid1 with 0x22 on alternating cycles.
- Held Req: requester 0 alone keeps Req high for 6 cycles. Expect exactly 3 Acks, never on consecutive cycles.
- Lock (RAM_ARB_LOCK_EN defined): requester 1 reads 0x20 with Lock=1 while requester 0 requests continuously. Expect no Ack0 until requester 1 writes 0x20 with Lock=0; Ack0 follows on the next eligible edge.
- Asynchronous reset one cycle after a read is granted: expect the following RdValid suppressed, all outputs 0, and a first grant to requester 0 after release when both request.
- Build without RAM_ARB_LOCK_EN and repeat the lock test: expect round-robin alternation, with i_Lock1 having no effect.
